sda_frame_tx: RTL and testbench

//  Parallel-to-serial transmitter for the team's two-wire scl/sda nibble link.

---
 rtl/sda_frame_tx.sv | 114 +++++++++++
 tb/tb_sda_frame_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_frame_tx.sv
// Nibble transmitter for the scl/sda link: start, 4 data bits MSB first, stop, then a gap.
// Each non-idle state lasts PHASE_CYC clks; scl/sda are registered push-pull outputs.
module sda_frame_tx #(
    parameter int unsigned PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       scl,
    output logic       sda
);

    localparam int unsigned CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CW-1:0] LastPhase = CW'(PHASE_CYC - 1);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StBFall,
        StBSet,
        StBHigh,
        StSFall,
        StSSet,
        StSHigh,
        StGap
    } state_t;

    state_t        state;
    logic [CW-1:0] phase_cnt;
    logic [3:0]    shreg;
    logic [1:0]    bitcnt;
    logic          phase_end;

    assign phase_end = (phase_cnt == LastPhase);

    // Outputs are set on the edge that enters each state, so scl and sda never move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            phase_cnt <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            scl       <= 1'b1;
            sda       <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == StIdle) begin
                if (data_valid && ready) begin
                    shreg     <= data;
                    bitcnt    <= 2'd3;
                    phase_cnt <= '0;
                    state     <= StStart;
                    sda       <= 1'b0;
                    ready     <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (!phase_end) begin
                phase_cnt <= phase_cnt + 1'b1;
            end else begin
                phase_cnt <= '0;
                unique case (state)
                    StStart: begin
                        state <= StBFall;
                        scl   <= 1'b0;
                    end
                    StBFall: begin
                        state <= StBSet;
                        sda   <= shreg[bitcnt];
                    end
                    StBSet: begin
                        state <= StBHigh;
                        scl   <= 1'b1;
                    end
                    StBHigh: begin
                        scl <= 1'b0;
                        if (bitcnt == 2'd0) begin
                            state <= StSFall;
                        end else begin
                            bitcnt <= bitcnt - 2'd1;
                            state  <= StBFall;
                        end
                    end
                    StSFall: begin
                        state <= StSSet;
                        sda   <= 1'b0;
                    end
                    StSSet: begin
                        state <= StSHigh;
                        scl   <= 1'b1;
                    end
                    StSHigh: begin
                        state <= StGap;
                        sda   <= 1'b1;
                        done  <= 1'b1;
                    end
                    StGap: begin
                        state <= StIdle;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sda_frame_tx.sv
// Scoreboard bench for sda_frame_tx: drivers queue expected frames, per-instance bus
// monitors decode scl/sda and compare data and event timing against the queue.
module tb_sda_frame_tx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] data_a  [2];
    logic       valid_a [2];
    logic       ready_v [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       scl_v   [2];
    logic       sda_v   [2];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         inst;
        logic [3:0] d;
        int         acc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sda_frame_tx #(.PHASE_CYC(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data_a[0]),
        .data_valid (valid_a[0]),
        .ready      (ready_v[0]),
        .busy       (busy_v[0]),
        .done       (done_v[0]),
        .scl        (scl_v[0]),
        .sda        (sda_v[0])
    );

    sda_frame_tx #(.PHASE_CYC(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data_a[1]),
        .data_valid (valid_a[1]),
        .ready      (ready_v[1]),
        .busy       (busy_v[1]),
        .done       (done_v[1]),
        .scl        (scl_v[1]),
        .sda        (sda_v[1])
    );

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // One bus monitor per instance; P is that instance's PHASE_CYC.
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int P = (g == 0) ? 4 : 1;
        logic       pscl     = 1'b1;
        logic       psda     = 1'b1;
        logic       prdy     = 1'b1;
        bit         in_frame = 1'b0;
        int         nbits    = 0;
        logic [3:0] sh       = '0;
        int         acc      = 0;
        int         last_acc = -1;

        always @(negedge clk) begin
            bit   start_now;
            bit   stop_now;
            exp_t e;
            start_now = 1'b0;
            stop_now  = 1'b0;
            if (!rst_n) begin
                // An aborted frame is dropped from the scoreboard.
                if (in_frame && exp_q.size() > 0 && exp_q[0].inst == g) e = exp_q.pop_front();
                in_frame = 1'b0;
                last_acc = -1;
            end else begin
                if (scl_v[g] && pscl && sda_v[g] != psda) begin
                    if (!sda_v[g] && !in_frame) start_now = 1'b1;
                    else if (sda_v[g] && in_frame && nbits == 4) stop_now = 1'b1;
                    else check($sformatf("sda_moved_while_scl_high_%0d", g), sda_v[g], psda);
                end
                if (scl_v[g] != pscl && sda_v[g] != psda)
                    check($sformatf("scl_sda_same_edge_%0d", g), sda_v[g], psda);
                if (start_now) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != g) begin
                        check($sformatf("unexpected_start_%0d", g), g, -1);
                    end else begin
                        in_frame = 1'b1;
                        nbits    = 0;
                        sh       = '0;
                        acc      = exp_q[0].acc;
                        check("start_time", cyc, acc);
                    end
                end
                if (in_frame && !pscl && scl_v[g]) begin
                    if (nbits < 4) begin
                        check("bit_rise_time", cyc, acc + (3 * nbits + 3) * P);
                        sh    = {sh[2:0], sda_v[g]};
                        nbits = nbits + 1;
                    end else begin
                        check("stop_setup_time", cyc, acc + 15 * P);
                    end
                end
                if (stop_now) begin
                    e = exp_q.pop_front();
                    check("frame_data", sh, e.d);
                    check("stop_time", cyc, acc + 16 * P);
                    check("done_at_stop", done_v[g], 1);
                    in_frame = 1'b0;
                    last_acc = acc;
                end else if (done_v[g]) begin
                    check($sformatf("done_spurious_%0d", g), done_v[g], 0);
                end
                if (ready_v[g] && !prdy && last_acc >= 0) begin
                    check("ready_return_time", cyc, last_acc + 17 * P);
                    last_acc = -1;
                end
            end
            pscl = scl_v[g];
            psda = sda_v[g];
            prdy = ready_v[g];
        end
    end

    task automatic send(input int inst, input logic [3:0] d, input bit hold, output int acc);
        int   k;
        exp_t e;
        @(negedge clk);
        data_a[inst]  = d;
        valid_a[inst] = 1'b1;
        k = 0;
        while (!ready_v[inst] && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!ready_v[inst]) begin
            check("accept_timeout", ready_v[inst], 1);
            valid_a[inst] = 1'b0;
            acc = -1;
        end else begin
            acc    = cyc + 1;
            e.inst = inst;
            e.d    = d;
            e.acc  = acc;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (!hold) valid_a[inst] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int inst);
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !ready_v[inst]) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || !ready_v[inst]) check("frame_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input int inst);
        check($sformatf("rst_scl_%0d", inst), scl_v[inst], 1);
        check($sformatf("rst_sda_%0d", inst), sda_v[inst], 1);
        check($sformatf("rst_ready_%0d", inst), ready_v[inst], 1);
        check($sformatf("rst_busy_%0d", inst), busy_v[inst], 0);
        check($sformatf("rst_done_%0d", inst), done_v[inst], 0);
    endtask

    initial begin
        int a1;
        int a2;
        for (int i = 0; i < 2; i++) begin
            data_a[i]  = 4'h0;
            valid_a[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame 1010 at PHASE_CYC=4.
        send(0, 4'b1010, 1'b0, a1);
        wait_idle(0);

        // Back-to-back with data_valid held; data swaps right after the first accept.
        send(0, 4'h1, 1'b1, a1);
        send(0, 4'hE, 1'b0, a2);
        check("frame_spacing", a2 - a1, 17 * 4 + 1);
        wait_idle(0);

        // Mid-frame request is ignored and data changes after accept have no effect.
        send(0, 4'h5, 1'b0, a1);
        data_a[0] = 4'h9;
        repeat (20) @(negedge clk);
        check("busy_mid_frame", busy_v[0], 1);
        check("ready_mid_frame", ready_v[0], 0);
        data_a[0]  = 4'hF;
        valid_a[0] = 1'b1;
        @(negedge clk);
        valid_a[0] = 1'b0;
        data_a[0]  = 4'h0;
        wait_idle(0);

        // Abort during B_HIGH of bit 2 (a 0 bit, so the reset edge mimics a stop).
        send(0, 4'hD, 1'b0, a1);
        while (cyc < a1 + 37) @(negedge clk);
        check("pre_abort_scl_high", scl_v[0], 1);
        check("pre_abort_sda_bit2", sda_v[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_queue_cleared", exp_q.size(), 0);
        send(0, 4'hD, 1'b0, a1);
        wait_idle(0);

        // PHASE_CYC=1 instance.
        send(1, 4'h6, 1'b0, a1);
        wait_idle(1);

        repeat (5) @(negedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
